cam_pwr_seq: RTL and testbench
==============================

CAM_PWR_SEQ -- requirements
Module: cam_pwr_seq

Interface
REQ-001 SHALL have parameter CNT_W, default 20: width of the shared cycle timer.
REQ-002 SHALL have parameter T_CLK, default 50000: cycles of cam_clk_en before power-down release.
REQ-003 SHALL have parameter T_RST, default 50000: cycles cam_rst_n is held low.
REQ-004 SHALL have parameter T_SETTLE, default 500000: cycles after reset release before the pclk check.
REQ-005 SHALL have parameter PCLK_MIN, default 16: synchronized pclk toggles needed to pass the check.
REQ-006 SHALL have parameter T_TIMEOUT, default 1000000: cycles allowed for the pclk check or between pclk toggles in READY.
REQ-007 SHALL have parameter MAX_RETRY, default 3: retries allowed before FAIL.
REQ-008 SHALL have port clk, input, 1: single clock (50 MHz system domain).
REQ-009 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-010 SHALL have port en, input, 1: level request to power the camera.
REQ-011 SHALL have port pclk_tgl, input, 1: toggles once per pixel-domain edge, asynchronous to clk.
REQ-012 SHALL have port cfg_done, input, 1: one-cycle pulse, SCCB configuration complete.
REQ-013 SHALL have port cfg_err, input, 1: one-cycle pulse, SCCB configuration failed.
REQ-014 SHALL have port cam_clk_en, output, 1: gate for the camera reference clock.
REQ-015 SHALL have port cam_pwdn, output, 1: camera power-down, active-high.
REQ-016 SHALL have port cam_rst_n, output, 1: camera reset, active-low.
REQ-017 SHALL have port cfg_req, output, 1: level request to the SCCB configurator.
REQ-018 SHALL have port ready, output, 1: camera streaming and configured.
REQ-019 SHALL have port fail, output, 1: retries exhausted.
REQ-020 SHALL have port state, output, 3: current state encoding.
REQ-021 SHALL have port retry_cnt, output, 2: retries consumed.

Function
REQ-022 SHALL implement states IDLE=0, PWRUP=1, RST=2, SETTLE=3, CHECK=4, CFG=5, READY=6, FAIL=7; every output is registered.
REQ-023 IDLE: cam_pwdn=1, cam_rst_n=0, cam_clk_en=0, retry_cnt cleared; en=1 -> PWRUP.
REQ-024 PWRUP: cam_clk_en=1, cam_pwdn=1; after T_CLK cycles -> RST.
REQ-025 RST: cam_pwdn=0, cam_rst_n=0; after T_RST cycles -> SETTLE.
REQ-026 SETTLE: cam_rst_n=1; after T_SETTLE cycles -> CHECK.
REQ-027 CHECK behaviour:
- pass pclk_tgl through a 2-flop synchronizer, then a 1-cycle edge detector;
- count edges (saturating);
- count reaches PCLK_MIN -> CFG;
- timer reaches T_TIMEOUT first -> retry;
- both events in the same cycle -> CFG.
REQ-028 CFG: cfg_req=1 until cfg_done or cfg_err.
- cfg_done -> READY;
- cfg_err -> retry;
- both in the same cycle -> retry;
- cfg_req deasserts in the cycle the state leaves CFG.
REQ-029 READY: ready=1; timer restarts on each synchronized pclk edge; T_TIMEOUT cycles with no edge -> retry.
REQ-030 Retry handling:
- retry_cnt==MAX_RETRY -> FAIL;
- otherwise retry_cnt+1 and -> PWRUP with cam_pwdn=1, cam_rst_n=0.
REQ-031 FAIL: outputs as IDLE plus fail=1; held until en=0.
REQ-032 en=0 in any state -> IDLE next cycle; this overrides every other transition.
REQ-033 Timer behaviour:
- a single CNT_W-bit counter cleared on every state entry;
- a state's "after N cycles" means exit on the Nth cycle in that state;
- the timer never wraps; it saturates at all-ones.

Reset
REQ-034 On reset, outputs SHALL take these values:
- state=IDLE;
- cam_clk_en=0, cam_pwdn=1, cam_rst_n=0;
- cfg_req=0, ready=0, fail=0;
- retry_cnt=0, timer=0, edge count=0, synchronizer flops=0.
REQ-035 Reset mid-operation SHALL abandon any sequence immediately; no SCCB request survives reset.

Structure
REQ-036 State encoding constants and default timing values SHALL live in the shared package cam_pkg.
REQ-037 The synchronizer plus edge detector SHALL be sub-module pclk_act_det; everything else stays flat.

Verification
All scenarios use params T_CLK=4, T_RST=8, T_SETTLE=16, PCLK_MIN=4, T_TIMEOUT=64, MAX_RETRY=2.
REQ-038 en=1, pclk_tgl toggling every 3 cycles, cfg_done 10 cycles after cfg_req -> state visits 1,2,3,4,5,6; cam_pwdn falls 4 cycles after PWRUP entry; ready=1, retry_cnt=0.
REQ-039 en=1, pclk_tgl static -> CHECK times out 3 times; retry_cnt counts 1 then 2; then FAIL with fail=1 and cam_clk_en=0.
REQ-040 Reach READY, then stop pclk_tgl -> after 64 idle cycles ready=0, state=PWRUP, retry_cnt=1.
REQ-041 In CFG, pulse cfg_done and cfg_err in the same cycle -> retry, not READY; cfg_req=0 the next cycle.
REQ-042 Deassert en during RST -> IDLE next cycle; cam_pwdn=1, cam_rst_n=0.
REQ-043 Assert reset mid-CFG -> all outputs at reset values asynchronously; restart from IDLE.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared state encoding, default timing values and the per-state output decode
// for the camera power sequencer.
package cam_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StPwrup  = 3'd1,
    StRst    = 3'd2,
    StSettle = 3'd3,
    StCheck  = 3'd4,
    StCfg    = 3'd5,
    StReady  = 3'd6,
    StFail   = 3'd7
  } cam_state_e;

  localparam int unsigned CntWDef     = 20;
  localparam int unsigned TClkDef     = 50000;
  localparam int unsigned TRstDef     = 50000;
  localparam int unsigned TSettleDef  = 500000;
  localparam int unsigned PclkMinDef  = 16;
  localparam int unsigned TTimeoutDef = 1000000;
  localparam int unsigned MaxRetryDef = 3;

  typedef struct packed {
    logic clk_en;
    logic pwdn;
    logic rst_n;
    logic cfg_req;
    logic ready;
    logic fail;
  } cam_out_t;

  // Output levels owned by each state; registered from the next state in the top.
  function automatic cam_out_t state_outs(input cam_state_e s);
    cam_out_t o;
    o = '{clk_en: 1'b1, pwdn: 1'b0, rst_n: 1'b1, cfg_req: 1'b0, ready: 1'b0, fail: 1'b0};
    case (s)
      StIdle: begin
        o.clk_en = 1'b0;
        o.pwdn   = 1'b1;
        o.rst_n  = 1'b0;
      end
      StPwrup: begin
        o.pwdn  = 1'b1;
        o.rst_n = 1'b0;
      end
      StRst:   o.rst_n   = 1'b0;
      StCfg:   o.cfg_req = 1'b1;
      StReady: o.ready   = 1'b1;
      StFail: begin
        o.clk_en = 1'b0;
        o.pwdn   = 1'b1;
        o.rst_n  = 1'b0;
        o.fail   = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/pclk_act_det.sv
// Two-flop synchronizer for the pixel-domain toggle, followed by a one-cycle
// edge pulse generator in the system clock domain.
module pclk_act_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tgl,
  output logic o_edge
);

  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_tgl};
      r_prev <= r_sync[1];
    end
  end

  assign o_edge = r_sync[1] ^ r_prev;

endmodule

// File: rtl/cam_pwr_seq.sv
// Camera power-up sequencer: clock enable, power-down release, reset release,
// pclk activity check, SCCB configuration handshake, streaming watchdog, retries.
module cam_pwr_seq
  import cam_pkg::*;
#(
  parameter int unsigned CNT_W     = CntWDef,
  parameter int unsigned T_CLK     = TClkDef,
  parameter int unsigned T_RST     = TRstDef,
  parameter int unsigned T_SETTLE  = TSettleDef,
  parameter int unsigned PCLK_MIN  = PclkMinDef,
  parameter int unsigned T_TIMEOUT = TTimeoutDef,
  parameter int unsigned MAX_RETRY = MaxRetryDef
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       pclk_tgl,
  input  logic       cfg_done,
  input  logic       cfg_err,
  output logic       cam_clk_en,
  output logic       cam_pwdn,
  output logic       cam_rst_n,
  output logic       cfg_req,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [1:0] retry_cnt
);

  localparam int unsigned EcntW = $clog2(PCLK_MIN + 1);

  // Timer holds (cycles in state - 1), so "after N cycles" fires at N-1.
  localparam logic [CNT_W-1:0] ClkLast     = CNT_W'(T_CLK - 1);
  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(T_RST - 1);
  localparam logic [CNT_W-1:0] SettleLast  = CNT_W'(T_SETTLE - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(T_TIMEOUT - 1);
  localparam logic [EcntW-1:0] EcntMin     = EcntW'(PCLK_MIN);
  localparam logic [1:0]       RetryMax    = 2'(MAX_RETRY);

  cam_state_e       r_state;
  cam_state_e       w_nxt;
  cam_out_t         r_out;
  logic [CNT_W-1:0] r_timer;
  logic [EcntW-1:0] r_ecnt;
  logic [EcntW-1:0] w_ecnt_nxt;
  logic [1:0]       r_retry;
  logic             w_retry;
  logic             w_edge;

  pclk_act_det u_pclk_act_det (
    .i_clk  (clk),
    .i_rst  (reset),
    .i_tgl  (pclk_tgl),
    .o_edge (w_edge)
  );

  always_comb begin
    w_ecnt_nxt = r_ecnt;
    if (r_state == StCheck && w_edge && r_ecnt != '1) begin
      w_ecnt_nxt = r_ecnt + EcntW'(1);
    end
  end

  always_comb begin
    w_nxt   = r_state;
    w_retry = 1'b0;
    unique case (r_state)
      StIdle:   if (en) w_nxt = StPwrup;
      StPwrup:  if (r_timer >= ClkLast) w_nxt = StRst;
      StRst:    if (r_timer >= RstLast) w_nxt = StSettle;
      StSettle: if (r_timer >= SettleLast) w_nxt = StCheck;
      StCheck: begin
        // Enough activity wins over a coincident timeout.
        if (w_ecnt_nxt >= EcntMin) w_nxt = StCfg;
        else if (r_timer >= TimeoutLast) w_retry = 1'b1;
      end
      StCfg: begin
        if (cfg_err) w_retry = 1'b1;
        else if (cfg_done) w_nxt = StReady;
      end
      StReady:  if (!w_edge && r_timer >= TimeoutLast) w_retry = 1'b1;
      StFail:   ;
    endcase
    if (w_retry) w_nxt = (r_retry == RetryMax) ? StFail : StPwrup;
    if (!en) w_nxt = StIdle;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_out   <= state_outs(StIdle);
      r_timer <= '0;
      r_ecnt  <= '0;
      r_retry <= 2'd0;
    end else begin
      r_state <= w_nxt;
      r_out   <= state_outs(w_nxt);
      if (w_nxt != r_state || (r_state == StReady && w_edge)) begin
        r_timer <= '0;
      end else if (r_timer != '1) begin
        r_timer <= r_timer + CNT_W'(1);
      end
      r_ecnt <= (w_nxt != r_state) ? '0 : w_ecnt_nxt;
      if (w_nxt == StIdle) begin
        r_retry <= 2'd0;
      end else if (w_retry && w_nxt == StPwrup) begin
        r_retry <= r_retry + 2'd1;
      end
    end
  end

  assign cam_clk_en = r_out.clk_en;
  assign cam_pwdn   = r_out.pwdn;
  assign cam_rst_n  = r_out.rst_n;
  assign cfg_req    = r_out.cfg_req;
  assign ready      = r_out.ready;
  assign fail       = r_out.fail;
  assign state      = r_state;
  assign retry_cnt  = r_retry;

endmodule

// File: tb/tb_cam_pwr_seq.sv
// Directed bench for cam_pwr_seq: expected state visits are queued as stimulus
// is applied and popped whenever the DUT state changes.
module tb_cam_pwr_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       pclk_tgl = 1'b0;
  logic       cfg_done = 1'b0;
  logic       cfg_err = 1'b0;
  logic       cam_clk_en, cam_pwdn, cam_rst_n, cfg_req, ready, fail;
  logic [2:0] state;
  logic [1:0] retry_cnt;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         t0;
  logic       pclk_run = 1'b0;
  int         div = 0;
  logic [2:0] last_state = 3'd0;
  logic [2:0] exp_q[$];

  cam_pwr_seq #(
    .CNT_W     (20),
    .T_CLK     (4),
    .T_RST     (8),
    .T_SETTLE  (16),
    .PCLK_MIN  (4),
    .T_TIMEOUT (64),
    .MAX_RETRY (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .pclk_tgl   (pclk_tgl),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .cam_clk_en (cam_clk_en),
    .cam_pwdn   (cam_pwdn),
    .cam_rst_n  (cam_rst_n),
    .cfg_req    (cfg_req),
    .ready      (ready),
    .fail       (fail),
    .state      (state),
    .retry_cnt  (retry_cnt)
  );

  always #5 clk = ~clk;

  // Pixel-domain activity: one toggle every 3 system cycles while enabled.
  always @(negedge clk) begin
    if (pclk_run) begin
      if (div == 2) begin
        div      <= 0;
        pclk_tgl <= ~pclk_tgl;
      end else begin
        div <= div + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    if (state !== last_state) begin
      if (exp_q.size() == 0) begin
        chk("state_unexpected", 32'(state), 32'(last_state));
      end else begin
        chk("state_seq", 32'(state), 32'(exp_q.pop_front()));
      end
      last_state = state;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      mon();
    end
  endtask

  task automatic wait_state(input logic [2:0] tgt, input int budget, input string tag);
    int n = 0;
    while (state !== tgt && n < budget) begin
      step(1);
      n++;
    end
    chk(tag, 32'(state), 32'(tgt));
  endtask

  initial begin
    // Reset values
    step(2);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'({cam_clk_en, cam_pwdn, cam_rst_n, cfg_req, ready, fail}), 32'b010000);
    chk("rst_retry", 32'(retry_cnt), 32'd0);
    reset = 1'b0;
    step(2);
    chk("idle_hold", 32'(state), 32'd0);

    // Nominal bring-up to READY
    for (int s = 1; s <= 6; s++) exp_q.push_back(3'(s));
    en = 1'b1;
    pclk_run = 1'b1;
    wait_state(3'd1, 10, "reach_pwrup");
    t0 = cyc;
    chk("pwrup_outs", 32'({cam_clk_en, cam_pwdn, cam_rst_n}), 32'b110);
    for (int i = 0; i < 50 && cam_pwdn; i++) step(1);
    chk("pwdn_fall_delay", 32'(cyc - t0), 32'd4);
    wait_state(3'd5, 200, "reach_cfg");
    chk("cfg_req_on", 32'(cfg_req), 32'd1);
    step(9);
    chk("cfg_hold", 32'(state), 32'd5);
    cfg_done = 1'b1;
    step(1);
    cfg_done = 1'b0;
    chk("ready_state", 32'(state), 32'd6);
    chk("ready_flags", 32'({ready, cfg_req, retry_cnt}), 32'b1000);
    chk("nominal_drained", 32'(exp_q.size()), 32'd0);

    // Streaming watchdog
    exp_q.push_back(3'd1);
    step(10);
    pclk_run = 1'b0;
    t0 = cyc;
    wait_state(3'd1, 150, "ready_timeout");
    chk("ready_hold_len", 32'((cyc - t0) >= 60), 32'd1);
    chk("ready_drop", 32'(ready), 32'd0);
    chk("retry_after_ready", 32'(retry_cnt), 32'd1);

    // Simultaneous cfg_done and cfg_err retries
    for (int s = 2; s <= 5; s++) exp_q.push_back(3'(s));
    pclk_run = 1'b1;
    wait_state(3'd5, 200, "reach_cfg2");
    exp_q.push_back(3'd1);
    cfg_done = 1'b1;
    cfg_err  = 1'b1;
    step(1);
    cfg_done = 1'b0;
    cfg_err  = 1'b0;
    chk("both_retry_state", 32'(state), 32'd1);
    chk("both_cfg_req", 32'(cfg_req), 32'd0);
    chk("both_retry_cnt", 32'(retry_cnt), 32'd2);

    // en dropped in RST
    exp_q.push_back(3'd2);
    wait_state(3'd2, 20, "reach_rst");
    exp_q.push_back(3'd0);
    en = 1'b0;
    step(1);
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_outs", 32'({cam_clk_en, cam_pwdn, cam_rst_n}), 32'b010);
    chk("abort_retry", 32'(retry_cnt), 32'd0);

    // Static pclk: three CHECK timeouts, then FAIL
    pclk_run = 1'b0;
    for (int k = 0; k < 3; k++) for (int s = 1; s <= 4; s++) exp_q.push_back(3'(s));
    exp_q.push_back(3'd7);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_state(3'd1, 200, "retry_pwrup");
      chk("retry_cnt_seq", 32'(retry_cnt), 32'(k));
      wait_state(3'd4, 200, "retry_check");
    end
    wait_state(3'd7, 200, "reach_fail");
    chk("fail_outs", 32'({cam_clk_en, cam_pwdn, cam_rst_n, fail}), 32'b0101);
    step(5);
    chk("fail_held", 32'(state), 32'd7);
    exp_q.push_back(3'd0);
    en = 1'b0;
    step(1);
    chk("fail_release", 32'({state, fail}), 32'b0000);

    // Asynchronous reset in CFG
    for (int s = 1; s <= 5; s++) exp_q.push_back(3'(s));
    en = 1'b1;
    pclk_run = 1'b1;
    wait_state(3'd5, 200, "reach_cfg3");
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_outs", 32'({cam_clk_en, cam_pwdn, cam_rst_n, cfg_req, ready, fail}),
        32'b010000);
    chk("async_rst_retry", 32'(retry_cnt), 32'd0);
    last_state = 3'd0;
    step(1);
    #2 reset = 1'b0;
    exp_q.push_back(3'd1);
    wait_state(3'd1, 10, "restart_pwrup");
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
